// File: rtl/aes_round_sequencer_pkg.sv
// Shared definitions for the AES-128 round sequencer.
// Holds the default round count and counter width, the FSM state encoding
// (3-bit) and the RoundType codes that the datapath decodes.
package aes_round_sequencer_pkg;

    localparam int NR_DEF    = 10;
    localparam int RND_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYFWD = 3'd1,
        ST_INIT   = 3'd2,
        ST_ROUND  = 3'd3,
        ST_FINAL  = 3'd4,
        ST_DONE   = 3'd5
    } seqState_t;

    localparam logic [1:0] RT_IDLE  = 2'b00;
    localparam logic [1:0] RT_INIT  = 2'b01;
    localparam logic [1:0] RT_FULL  = 2'b10;
    localparam logic [1:0] RT_FINAL = 2'b11;

endpackage

// File: rtl/aes_round_sequencer_counter.sv
// Round index counter for the AES round sequencer.
// Ports:
//   Clk, Rst          clock and synchronous active-low reset
//   load, loadVal     load an explicit round index (wins over counting)
//   countUp/countDown step the index by one
//   count             current round index
//   atNrMinus1/atOne/atNr  exact-compare terminal flags used by the FSM
module aes_round_sequencer_counter
    import aes_round_sequencer_pkg::*;
#(
    parameter int NR    = NR_DEF,
    parameter int RND_W = RND_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             load,
    input  logic [RND_W-1:0] loadVal,
    input  logic             countUp,
    input  logic             countDown,
    output logic [RND_W-1:0] count,
    output logic             atNrMinus1,
    output logic             atOne,
    output logic             atNr
);

    // The FSM never asks for a step past 0 or NR, so no saturation is needed.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (countUp) begin
            count <= count + RND_W'(1);
        end else if (countDown) begin
            count <= count - RND_W'(1);
        end
    end

    assign atNrMinus1 = (count == RND_W'(NR - 1));
    assign atOne      = (count == RND_W'(1));
    assign atNr       = (count == RND_W'(NR));

endmodule

// File: rtl/aes_round_sequencer.sv
// Control FSM for an iterative AES-128 datapath (one round per clock).
// Accepts a block via ReadRy/ReadEn, returns it via WriteEn/WriteRy, and
// steers state/key loading, round type, round index and key-schedule
// stepping. The cipher key and the round-10 key are cached so that a later
// decrypt with the same key skips forward key expansion.
// Ports:
//   Clk, Rst                 clock, synchronous active-low reset
//   ProgramSelector          1=encrypt, 0=decrypt (sampled at accept)
//   ReadyKey                 new key accompanies this block (sampled at accept)
//   ReadRy / ReadEn          host input handshake; ReadEn is the accept pulse
//   WriteRy / WriteEn        host output handshake; WriteEn held until WriteRy
//   LoadState/LoadKey/LoadWork/KeySrc  register load controls
//   KeyStep/KeyDir/CaptureLastKey      key schedule controls
//   RoundType/Inverse/RoundCnt         datapath round controls
//   Busy                     high whenever not idle
module aes_round_sequencer
    import aes_round_sequencer_pkg::*;
#(
    parameter int NR    = NR_DEF,
    parameter int RND_W = RND_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ProgramSelector,
    input  logic             ReadyKey,
    input  logic             ReadRy,
    input  logic             WriteRy,
    output logic             ReadEn,
    output logic             WriteEn,
    output logic             LoadState,
    output logic             LoadKey,
    output logic             LoadWork,
    output logic             KeySrc,
    output logic             KeyStep,
    output logic             KeyDir,
    output logic             CaptureLastKey,
    output logic [1:0]       RoundType,
    output logic             Inverse,
    output logic [RND_W-1:0] RoundCnt,
    output logic             Busy
);

    localparam logic [RND_W-1:0] CNT_NR   = RND_W'(NR);
    localparam logic [RND_W-1:0] CNT_ONE  = RND_W'(1);
    localparam logic [RND_W-1:0] CNT_ZERO = '0;

    seqState_t        state, nextState;
    logic             keyValid, lastKeyValid, encMode;
    logic             cntLoad, cntUp, cntDown;
    logic [RND_W-1:0] cntLoadVal, cnt;
    logic             atNrMinus1, atOne, atNr;
    logic             useCached;

    aes_round_sequencer_counter #(.NR(NR), .RND_W(RND_W)) roundCounter (
        .Clk        (Clk),
        .Rst        (Rst),
        .load       (cntLoad),
        .loadVal    (cntLoadVal),
        .countUp    (cntUp),
        .countDown  (cntDown),
        .count      (cnt),
        .atNrMinus1 (atNrMinus1),
        .atOne      (atOne),
        .atNr       (atNr)
    );

    // State, latched mode and key-cache flags. A new key invalidates the
    // cached last key until this block's schedule reaches round 10 again.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state        <= ST_IDLE;
            keyValid     <= 1'b0;
            lastKeyValid <= 1'b0;
            encMode      <= 1'b0;
        end else begin
            state <= nextState;
            if (ReadEn) begin
                encMode <= ProgramSelector;
                if (ReadyKey) begin
                    keyValid     <= 1'b1;
                    lastKeyValid <= 1'b0;
                end
            end
            if (CaptureLastKey) begin
                lastKeyValid <= 1'b1;
            end
        end
    end

    // Next-state and output decode. Accept is gated by Rst so nothing is
    // consumed while reset is being applied.
    always_comb begin
        nextState      = state;
        ReadEn         = 1'b0;
        WriteEn        = 1'b0;
        LoadState      = 1'b0;
        LoadKey        = 1'b0;
        LoadWork       = 1'b0;
        KeySrc         = 1'b0;
        KeyStep        = 1'b0;
        KeyDir         = 1'b0;
        CaptureLastKey = 1'b0;
        RoundType      = RT_IDLE;
        Inverse        = 1'b0;
        RoundCnt       = CNT_ZERO;
        Busy           = (state != ST_IDLE);
        cntLoad        = 1'b0;
        cntLoadVal     = CNT_ZERO;
        cntUp          = 1'b0;
        cntDown        = 1'b0;
        useCached      = !ProgramSelector && lastKeyValid && !ReadyKey;

        case (state)
            ST_IDLE: begin
                if (Rst && ReadRy && (ReadyKey || keyValid)) begin
                    ReadEn    = 1'b1;
                    LoadState = 1'b1;
                    LoadKey   = ReadyKey;
                    LoadWork  = 1'b1;
                    KeySrc    = useCached;
                    cntLoad   = 1'b1;
                    if (ProgramSelector) begin
                        nextState  = ST_INIT;
                        cntLoadVal = CNT_ZERO;
                    end else if (useCached) begin
                        nextState  = ST_INIT;
                        cntLoadVal = CNT_NR;
                    end else begin
                        nextState  = ST_KEYFWD;
                        cntLoadVal = CNT_ONE;
                    end
                end
            end
            // Walk the schedule forward to the round-10 key before decrypting.
            ST_KEYFWD: begin
                KeyStep  = 1'b1;
                RoundCnt = cnt;
                if (atNr) begin
                    nextState  = ST_INIT;
                    cntLoad    = 1'b1;
                    cntLoadVal = CNT_NR;
                end else begin
                    cntUp = 1'b1;
                end
            end
            ST_INIT: begin
                RoundType = RT_INIT;
                RoundCnt  = cnt;
                KeyStep   = 1'b1;
                KeyDir    = !encMode;
                Inverse   = !encMode;
                nextState = ST_ROUND;
                if (encMode) begin
                    cntUp = 1'b1;
                end else begin
                    cntDown        = 1'b1;
                    CaptureLastKey = 1'b1;
                end
            end
            ST_ROUND: begin
                RoundType = RT_FULL;
                RoundCnt  = cnt;
                KeyStep   = 1'b1;
                KeyDir    = !encMode;
                Inverse   = !encMode;
                if (encMode) begin
                    cntUp = 1'b1;
                    if (atNrMinus1) nextState = ST_FINAL;
                end else begin
                    cntDown = 1'b1;
                    if (atOne) nextState = ST_FINAL;
                end
            end
            ST_FINAL: begin
                RoundType      = RT_FINAL;
                RoundCnt       = cnt;
                Inverse        = !encMode;
                CaptureLastKey = encMode;
                nextState      = ST_DONE;
                cntLoad        = 1'b1;
                cntLoadVal     = CNT_ZERO;
            end
            ST_DONE: begin
                WriteEn = 1'b1;
                Inverse = !encMode;
                if (WriteRy) nextState = ST_IDLE;
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: directed operations with a
// per-cycle reference model of the control outputs and a scoreboard of
// expected completion latency and mode.
module tb_aes_round_sequencer;

    logic       Clk = 1'b0;
    logic       Rst, ProgramSelector, ReadyKey, ReadRy, WriteRy;
    logic       ReadEn, WriteEn, LoadState, LoadKey, LoadWork, KeySrc;
    logic       KeyStep, KeyDir, CaptureLastKey, Inverse, Busy;
    logic [1:0] RoundType;
    logic [3:0] RoundCnt;

    typedef struct packed {
        logic [1:0] rt;
        logic [3:0] cnt;
        logic       readEn;
        logic       writeEn;
        logic       loadState;
        logic       loadKey;
        logic       loadWork;
        logic       keySrc;
        logic       keyStep;
        logic       keyDir;
        logic       capture;
        logic       inv;
        logic       busy;
    } obs_t;

    typedef struct packed {
        int   lat;
        logic inv;
    } sbEntry_t;

    sbEntry_t sbQ[$];
    int       checks = 0;
    int       errors = 0;
    bit       modelLastValid = 1'b0;

    aes_round_sequencer dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .ProgramSelector (ProgramSelector),
        .ReadyKey        (ReadyKey),
        .ReadRy          (ReadRy),
        .WriteRy         (WriteRy),
        .ReadEn          (ReadEn),
        .WriteEn         (WriteEn),
        .LoadState       (LoadState),
        .LoadKey         (LoadKey),
        .LoadWork        (LoadWork),
        .KeySrc          (KeySrc),
        .KeyStep         (KeyStep),
        .KeyDir          (KeyDir),
        .CaptureLastKey  (CaptureLastKey),
        .RoundType       (RoundType),
        .Inverse         (Inverse),
        .RoundCnt        (RoundCnt),
        .Busy            (Busy)
    );

    always #5 Clk = ~Clk;

    function automatic obs_t sample();
        obs_t o;
        o.rt        = RoundType;
        o.cnt       = RoundCnt;
        o.readEn    = ReadEn;
        o.writeEn   = WriteEn;
        o.loadState = LoadState;
        o.loadKey   = LoadKey;
        o.loadWork  = LoadWork;
        o.keySrc    = KeySrc;
        o.keyStep   = KeyStep;
        o.keyDir    = KeyDir;
        o.capture   = CaptureLastKey;
        o.inv       = Inverse;
        o.busy      = Busy;
        return o;
    endfunction

    // Expected outputs k cycles after the accept cycle.
    function automatic obs_t expOut(int k, bit enc, bit fresh);
        obs_t o;
        int   j;
        o      = '0;
        o.busy = 1'b1;
        if (fresh && k <= 10) begin
            o.cnt     = 4'(k);
            o.keyStep = 1'b1;
            return o;
        end
        j = fresh ? k - 10 : k;
        if (j == 1) begin
            o.rt      = 2'b01;
            o.cnt     = enc ? 4'd0 : 4'd10;
            o.keyStep = 1'b1;
            o.keyDir  = !enc;
            o.capture = !enc;
            o.inv     = !enc;
        end else if (j <= 10) begin
            o.rt      = 2'b10;
            o.cnt     = enc ? 4'(j - 1) : 4'(11 - j);
            o.keyStep = 1'b1;
            o.keyDir  = !enc;
            o.inv     = !enc;
        end else if (j == 11) begin
            o.rt      = 2'b11;
            o.cnt     = enc ? 4'd10 : 4'd0;
            o.capture = enc;
            o.inv     = !enc;
        end else begin
            o.writeEn = 1'b1;
            o.inv     = !enc;
        end
        return o;
    endfunction

    task automatic checkOutput(input string tag, input obs_t exp);
        obs_t got;
        got = sample();
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One block: accept, per-cycle model comparison, scoreboard pop at the
    // first WriteEn. abortAt>0 applies reset on that cycle instead.
    task automatic applyStimulus(input bit enc, input bit newKey, input int wrDelay,
                                 input bit toggle, input int abortAt);
        bit       fresh;
        bit       done;
        bit       gotWrite;
        int       lat;
        obs_t     e;
        sbEntry_t sb;
        fresh    = !enc && (newKey || !modelLastValid);
        lat      = fresh ? 22 : 12;
        done     = 1'b0;
        gotWrite = 1'b0;

        @(posedge Clk); #1;
        Rst = 1'b1; ReadRy = 1'b1; ReadyKey = newKey; ProgramSelector = enc; WriteRy = 1'b0;
        @(negedge Clk);
        e           = '0;
        e.readEn    = 1'b1;
        e.loadState = 1'b1;
        e.loadWork  = 1'b1;
        e.loadKey   = newKey;
        e.keySrc    = !enc && !fresh;
        checkOutput($sformatf("accept enc=%0d newKey=%0d", enc, newKey), e);
        if (ReadEn !== 1'b1) return;
        sbQ.push_back('{lat, !enc});
        if (newKey) modelLastValid = 1'b0;

        for (int k = 1; k <= 40 && !done; k++) begin
            @(posedge Clk); #1;
            ReadRy          = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
            ReadyKey        = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
            ProgramSelector = toggle ? 1'($urandom_range(0, 1)) : enc;
            WriteRy         = (k >= lat + wrDelay) ? 1'b1
                              : (toggle ? 1'($urandom_range(0, 1)) : 1'b0);
            Rst             = (k == abortAt) ? 1'b0 : 1'b1;
            @(negedge Clk);
            checkOutput($sformatf("cycle A+%0d enc=%0d", k, enc), expOut(k, enc, fresh));
            if (k == abortAt) begin
                @(posedge Clk); #1;
                Rst = 1'b1; ReadRy = 1'b1; ReadyKey = 1'b0; WriteRy = 1'b0;
                void'(sbQ.pop_front());
                modelLastValid = 1'b0;
                for (int r = 0; r < 3; r++) begin
                    @(negedge Clk);
                    checkOutput($sformatf("afterAbort%0d", r), '0);
                    @(posedge Clk); #1;
                end
                ReadRy = 1'b0;
                return;
            end
            if (WriteEn === 1'b1 && !gotWrite) begin
                gotWrite = 1'b1;
                checks++;
                if (sbQ.size() == 0) begin
                    errors++;
                    $error("FAIL scoreboard empty at A+%0d", k);
                end else begin
                    sb = sbQ.pop_front();
                    assert (k === sb.lat && Inverse === sb.inv)
                    else begin
                        errors++;
                        $error("FAIL latency observed=A+%0d inv=%0b expected=A+%0d inv=%0b",
                               k, Inverse, sb.lat, sb.inv);
                    end
                end
            end
            if (WriteEn === 1'b1 && WriteRy === 1'b1) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL timeout observed=no completion expected=completion at A+%0d", lat + wrDelay);
        end
        modelLastValid = 1'b1;
    endtask

    initial begin
        Rst = 1'b0; ReadRy = 1'b1; ReadyKey = 1'b1; ProgramSelector = 1'b1; WriteRy = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checkOutput("inReset", '0);
        @(posedge Clk); #1;
        Rst = 1'b1; ReadyKey = 1'b0;
        @(negedge Clk);
        checkOutput("noKeyWait0", '0);
        @(posedge Clk); #1;
        @(negedge Clk);
        checkOutput("noKeyWait1", '0);

        applyStimulus(1'b1, 1'b1, 0, 1'b0, 6);   // reset mid-ROUND at RoundCnt=5
        applyStimulus(1'b1, 1'b1, 0, 1'b0, 0);   // encrypt with new key
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);   // decrypt using cached last key
        applyStimulus(1'b0, 1'b1, 0, 1'b0, 0);   // decrypt with new key: KEYFWD
        applyStimulus(1'b1, 1'b0, 5, 1'b0, 0);   // host stalls WriteRy 5 cycles
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 0);   // inputs toggled while busy (dec)
        applyStimulus(1'b1, 1'b0, 0, 1'b1, 0);   // inputs toggled while busy (enc)

        checks++;
        assert (sbQ.size() == 0)
        else begin
            errors++;
            $error("FAIL scoreboard leftover observed=%0d expected=0", sbQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=no finish expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
